// File: rtl/ac_motor_pwm.sv
// ac_motor_pwm: three-phase centre-aligned PWM with complementary gates and dead time.
// One shared triangle carrier; duties are double-buffered and latched at the valley.
// Optional macro AC_MOTOR_PWM_BRAKE_EN adds a 'brake' input that forces all phases
// to their low sides (dynamic braking) through the normal dead-time path.
module ac_motor_pwm #(
    parameter int SINE_W   = 24,
    parameter int CNT_W    = 12,
    parameter int DEADTIME = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
`ifdef AC_MOTOR_PWM_BRAKE_EN
    input  logic                     brake,
`endif
    input  logic signed [SINE_W-1:0] sine1,
    input  logic signed [SINE_W-1:0] sine2,
    input  logic signed [SINE_W-1:0] sine3,
    output logic                     hs1,
    output logic                     ls1,
    output logic                     hs2,
    output logic                     ls2,
    output logic                     hs3,
    output logic                     ls3,
    output logic                     sync
);

    localparam int               DT_W     = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DT_W-1:0]  DT_LOAD  = DT_W'(DEADTIME - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_PEAK = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TURN = CNT_PEAK - CNT_W'(1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_HS   = 2'd1,
        ST_LS   = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    logic [CNT_W-1:0]         r_cnt;
    logic                     r_dir_up;
    logic                     w_latch;
    logic                     w_force_low;
    logic signed [SINE_W-1:0] w_sine [3];
    logic [2:0]               w_hs;
    logic [2:0]               w_ls;

    assign w_sine[0] = sine1;
    assign w_sine[1] = sine2;
    assign w_sine[2] = sine3;

`ifdef AC_MOTOR_PWM_BRAKE_EN
    assign w_force_low = brake & enable;
`else
    assign w_force_low = 1'b0;
`endif

    // Duty latch instant: valley of a running carrier. The sync pulse mirrors it,
    // and is gated by rst_n so it drops immediately when reset is asserted.
    assign w_latch = enable & (r_cnt == '0);
    assign sync    = w_latch & rst_n;

    // Triangle carrier 0..PEAK..0 without repeated endpoints; held at valley when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_dir_up <= 1'b1;
        end else if (!enable) begin
            r_cnt    <= '0;
            r_dir_up <= 1'b1;
        end else if (r_dir_up) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_TURN) r_dir_up <= 1'b0;
        end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_dir_up <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_phase
            logic [CNT_W-1:0] w_ref;
            logic [CNT_W-1:0] r_duty;
            logic             r_cmd;
            logic             w_cmd_next;
            state_t           r_state;
            state_t           w_state_next;
            logic [DT_W-1:0]  r_dead;
            logic [DT_W-1:0]  w_dead_next;
            logic             r_hs;
            logic             r_ls;
            logic             w_unused_lsbs;

            // (sine >>> (SINE_W-CNT_W)) + 2**(CNT_W-1) truncated to CNT_W bits is the
            // top CNT_W bits of the sine with the sign bit inverted (offset binary).
            assign w_ref         = {~w_sine[gi][SINE_W-1], w_sine[gi][SINE_W-2 -: CNT_W-1]};
            assign w_unused_lsbs = ^w_sine[gi][SINE_W-CNT_W-1:0];
            assign w_cmd_next    = (r_duty > r_cnt) & ~w_force_low;

            // Double-buffered duty, updated only at the carrier valley.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_duty <= CNT_MID;
                end else if (w_latch) begin
                    r_duty <= w_ref;
                end
            end

            // Registered compare: high-side request, one clk behind the carrier.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cmd <= 1'b0;
                end else begin
                    r_cmd <= w_cmd_next;
                end
            end

            // Gate FSM next state: every hs<->ls handover passes through DEAD.
            always_comb begin
                w_state_next = r_state;
                w_dead_next  = r_dead;
                if (!enable) begin
                    w_state_next = ST_OFF;
                end else begin
                    case (r_state)
                        ST_OFF: begin
                            w_state_next = ST_DEAD;
                            w_dead_next  = DT_LOAD;
                        end
                        ST_HS: begin
                            if (!r_cmd) begin
                                w_state_next = ST_DEAD;
                                w_dead_next  = DT_LOAD;
                            end
                        end
                        ST_LS: begin
                            if (r_cmd) begin
                                w_state_next = ST_DEAD;
                                w_dead_next  = DT_LOAD;
                            end
                        end
                        ST_DEAD: begin
                            if (r_dead == '0) begin
                                w_state_next = r_cmd ? ST_HS : ST_LS;
                            end else begin
                                w_dead_next = r_dead - DT_W'(1);
                            end
                        end
                        default: w_state_next = ST_OFF;
                    endcase
                end
            end

            // Gate FSM state, dead timer and registered gate outputs.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= ST_OFF;
                    r_dead  <= '0;
                    r_hs    <= 1'b0;
                    r_ls    <= 1'b0;
                end else begin
                    r_state <= w_state_next;
                    r_dead  <= w_dead_next;
                    r_hs    <= (w_state_next == ST_HS);
                    r_ls    <= (w_state_next == ST_LS);
                end
            end

            assign w_hs[gi] = r_hs;
            assign w_ls[gi] = r_ls;
        end
    endgenerate

    assign hs1 = w_hs[0];
    assign ls1 = w_ls[0];
    assign hs2 = w_hs[1];
    assign ls2 = w_ls[1];
    assign hs3 = w_hs[2];
    assign ls3 = w_ls[2];

endmodule
